ps2_message_assembler: RTL and testbench

//  Collects ASCII characters typed on the PS2 keyboard into a fixed-length message for the GPIO link.

---
 rtl/ps2_message_assembler.sv | 88 ++++++++
 tb/tb_ps2_message_assembler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ps2_message_assembler.sv
// Collects ASCII chars from key2ascii into a fixed-length message; Enter hands it to gpio_protocol.
// Latency: 1 cycle from char_valid to message_out/char_count. Backpressure: chars are dropped while a message is in flight.
module ps2_message_assembler #(
    parameter int         MSG_BYTES  = 16,
    parameter logic [7:0] CHAR_BS    = 8'h08,
    parameter logic [7:0] CHAR_ENTER = 8'h0D,
    parameter logic [7:0] PAD_CHAR   = 8'h00
) (
    input  logic                               clock,
    input  logic                               resetn,
    input  logic                               char_valid,
    input  logic [7:0]                         char_in,
    input  logic                               send_done,
    output logic [8*MSG_BYTES-1:0]             message_out,
    output logic                               data_ready,
    output logic [$clog2(MSG_BYTES+1)-1:0]     char_count,
    output logic                               buf_full,
    output logic                               overflow
);

    localparam int            CW       = $clog2(MSG_BYTES + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MSG_BYTES);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic {EDIT, SEND} state_t;

    state_t     state;
    logic [7:0] msg_q [MSG_BYTES];
    logic       send_done_q;
    logic       printable;
    logic       done_rise;

    assign printable = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign done_rise = send_done & ~send_done_q;
    assign buf_full  = (char_count == FULL_CNT);

    // Byte 0 lands in the MSBs so the link shifts the first typed char out first.
    for (genvar g = 0; g < MSG_BYTES; g++) begin : g_pack
        assign message_out[8*(MSG_BYTES-g)-1 -: 8] = msg_q[g];
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= EDIT;
            char_count  <= '0;
            data_ready  <= 1'b0;
            overflow    <= 1'b0;
            send_done_q <= 1'b0;
            for (int i = 0; i < MSG_BYTES; i++) msg_q[i] <= PAD_CHAR;
        end else begin
            send_done_q <= send_done;
            if (state == EDIT) begin
                if (char_valid) begin
                    if (printable) begin
                        if (buf_full) begin
                            overflow <= 1'b1;
                        end else begin
                            for (int i = 0; i < MSG_BYTES; i++)
                                if (i == int'(char_count)) msg_q[i] <= char_in;
                            char_count <= char_count + ONE;
                        end
                    end else if (char_in == CHAR_BS) begin
                        if (char_count != '0) begin
                            for (int i = 0; i < MSG_BYTES; i++)
                                if (i + 1 == int'(char_count)) msg_q[i] <= PAD_CHAR;
                            char_count <= char_count - ONE;
                        end
                    end else if (char_in == CHAR_ENTER) begin
                        if (char_count != '0) begin
                            state      <= SEND;
                            data_ready <= 1'b1;
                        end
                    end
                end
            end else begin
                // Only a fresh rising edge completes; a level already high on entry is ignored.
                if (done_rise) begin
                    state      <= EDIT;
                    data_ready <= 1'b0;
                    char_count <= '0;
                    overflow   <= 1'b0;
                    for (int i = 0; i < MSG_BYTES; i++) msg_q[i] <= PAD_CHAR;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_message_assembler.sv
// Vector table + scoreboard bench for ps2_message_assembler (MSG_BYTES=16).
module tb_ps2_message_assembler;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         char_valid = 1'b0;
    logic [7:0]   char_in = 8'h00;
    logic         send_done = 1'b0;
    logic [127:0] message_out;
    logic         data_ready;
    logic [4:0]   char_count;
    logic         buf_full;
    logic         overflow;

    int errors = 0;
    int nchecks = 0;

    ps2_message_assembler dut (
        .clock       (clock),
        .resetn      (resetn),
        .char_valid  (char_valid),
        .char_in     (char_in),
        .send_done   (send_done),
        .message_out (message_out),
        .data_ready  (data_ready),
        .char_count  (char_count),
        .buf_full    (buf_full),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rstn;
        logic        cv;
        logic [7:0]  ch;
        logic        sd;
        logic [4:0]  cnt;
        logic        rdy;
        logic        ovf;
        logic [31:0] top;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic rstn, logic cv, logic [7:0] ch, logic sd,
                                logic [4:0] cnt, logic rdy, logic ovf, logic [31:0] top);
        vec_t v;
        v.rstn = rstn; v.cv = cv; v.ch = ch; v.sd = sd;
        v.cnt = cnt; v.rdy = rdy; v.ovf = ovf; v.top = top;
        return v;
    endfunction

    function automatic void add(logic rstn, logic cv, logic [7:0] ch, logic sd,
                                logic [4:0] cnt, logic rdy, logic ovf, logic [31:0] top);
        tbl.push_back(mk(rstn, cv, ch, sd, cnt, rdy, ovf, top));
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One vector = one clock edge; expected record travels through the scoreboard queue.
    task automatic step(input vec_t v, input string tag, input bit chk_rest);
        vec_t e;
        @(negedge clock);
        resetn     = v.rstn;
        char_valid = v.cv;
        char_in    = v.ch;
        send_done  = v.sd;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check({tag, " count"},    128'(char_count),          128'(e.cnt));
        check({tag, " ready"},    128'(data_ready),          128'(e.rdy));
        check({tag, " overflow"}, 128'(overflow),            128'(e.ovf));
        check({tag, " full"},     128'(buf_full),            128'(e.cnt == 5'd16));
        check({tag, " top"},      128'(message_out[127:96]), 128'(e.top));
        if (chk_rest)
            check({tag, " rest"}, 128'(message_out[95:0]),   128'(0));
    endtask

    initial begin
        vec_t         v;
        logic [31:0]  top;
        logic [127:0] exp_msg;
        logic [4:0]   cnt;

        // reset, "HI", Enter, then send_done rise and a long high level
        add(0,0,8'h00,0, 0,0,0,32'h0);
        add(1,1,8'h48,0, 1,0,0,32'h48000000);
        add(1,1,8'h49,0, 2,0,0,32'h48490000);
        add(1,1,8'h0D,0, 2,1,0,32'h48490000);
        add(1,0,8'h00,0, 2,1,0,32'h48490000);
        add(1,0,8'h00,1, 0,0,0,32'h0);
        for (int i = 0; i < 10; i++) add(1,0,8'h00,1, 0,0,0,32'h0);
        // editing with backspace, underflow guard, non-printables
        add(1,1,8'h41,1, 1,0,0,32'h41000000);
        add(1,1,8'h42,0, 2,0,0,32'h41420000);
        add(1,1,8'h08,0, 1,0,0,32'h41000000);
        add(1,1,8'h43,0, 2,0,0,32'h41430000);
        add(1,1,8'h08,0, 1,0,0,32'h41000000);
        add(1,1,8'h08,0, 0,0,0,32'h0);
        add(1,1,8'h08,0, 0,0,0,32'h0);
        add(1,1,8'h0D,0, 0,0,0,32'h0);
        add(1,1,8'h01,0, 0,0,0,32'h0);
        add(1,1,8'h7F,0, 0,0,0,32'h0);
        add(1,1,8'h20,0, 1,0,0,32'h20000000);
        add(1,1,8'h7E,0, 2,0,0,32'h207E0000);
        add(1,1,8'h1F,0, 2,0,0,32'h207E0000);
        add(1,1,8'h08,0, 1,0,0,32'h20000000);
        add(1,1,8'h08,0, 0,0,0,32'h0);
        // chars ignored during SEND; char coincident with rise is lost
        add(1,1,8'h58,0, 1,0,0,32'h58000000);
        add(1,1,8'h0D,0, 1,1,0,32'h58000000);
        add(1,1,8'h59,0, 1,1,0,32'h58000000);
        add(1,1,8'h08,0, 1,1,0,32'h58000000);
        add(1,1,8'h0D,0, 1,1,0,32'h58000000);
        add(1,1,8'h5A,1, 0,0,0,32'h0);
        add(1,1,8'h51,1, 1,0,0,32'h51000000);
        add(1,0,8'h00,0, 1,0,0,32'h51000000);
        // reset mid-SEND, then send_done already high on entry
        add(1,1,8'h0D,0, 1,1,0,32'h51000000);
        add(0,0,8'h00,0, 0,0,0,32'h0);
        add(1,1,8'h4B,0, 1,0,0,32'h4B000000);
        add(1,0,8'h00,1, 1,0,0,32'h4B000000);
        add(1,1,8'h0D,1, 1,1,0,32'h4B000000);
        for (int i = 0; i < 3; i++) add(1,0,8'h00,1, 1,1,0,32'h4B000000);
        add(1,0,8'h00,0, 1,1,0,32'h4B000000);
        add(1,0,8'h00,1, 0,0,0,32'h0);
        add(1,0,8'h00,0, 0,0,0,32'h0);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i), 1'b1);

        // 17 chars 'a'..'q': last one overflows
        top = 32'h0;
        for (int i = 0; i < 17; i++) begin
            if (i < 4) top[31-8*i -: 8] = 8'(8'h61 + i);
            cnt = (i < 16) ? 5'(i + 1) : 5'd16;
            v = mk(1, 1, 8'(8'h61 + i), 0, cnt, 0, (i == 16), top);
            step(v, $sformatf("fill%0d", i), 1'b0);
        end
        exp_msg = '0;
        for (int i = 0; i < 16; i++) exp_msg[127-8*i -: 8] = 8'(8'h61 + i);
        check("full message", message_out, exp_msg);

        step(mk(1,1,8'h0D,0, 16,1,1,32'h61626364), "full enter", 1'b0);
        check("full message in send", message_out, exp_msg);
        step(mk(1,0,8'h00,1, 0,0,0,32'h0), "full clear", 1'b1);
        step(mk(1,0,8'h00,0, 0,0,0,32'h0), "idle", 1'b1);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, nchecks);
        $finish;
    end

endmodule
